div_unit: RTL and testbench

Iterative 32-bit integer divide/remainder unit for the execute stage, complementing the single-cycle ALU. The ALU owns MUL; this block covers the inverse operations DIV, DIVU, REM and REMU with RISC-V semantics. It is a multi-cycle unit that the pipeline drives through a start/busy/done handshake, and stalls on while the unit is busy. Operands are captured at start, so the pipeline may change them freely afterwards.

---
 rtl/div_unit.sv | 143 ++++++++++++++
 tb/tb_div_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: restoring division on operand magnitudes,
// one quotient bit per cycle, then sign fix-up. state | meaning:
//   IDLE | waiting for Start_i
//   CALC | one restoring step per cycle, counter 0..DATA_W-1
//   FIX  | sign correction, result select, register into DivResult_o
//   DONE | Done_o pulse; may accept the next request with no bubble
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Start_i,
    input  logic              Flush_i,
    input  logic [1:0]        DivOp_i,
    input  logic [DATA_W-1:0] Data1_i,
    input  logic [DATA_W-1:0] Data2_i,
    output logic              Busy_o,
    output logic              Done_o,
    output logic [DATA_W-1:0] DivResult_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [5:0]        LAST    = 6'(DATA_W - 1);
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              sign1_q, sign1_d;
    logic              sign2_q, sign2_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              accept;
    logic              signed_in;
    logic              neg1_in, neg2_in;
    logic              div_zero, overflow;
    logic [DATA_W:0]   rem_sh, diff;
    logic [DATA_W-1:0] q_fix, r_fix;

    assign accept    = (state_q == S_IDLE || state_q == S_DONE) && Start_i && !Flush_i;
    assign signed_in = ~DivOp_i[0];
    assign neg1_in   = signed_in & Data1_i[DATA_W-1];
    assign neg2_in   = signed_in & Data2_i[DATA_W-1];
    assign div_zero  = (Data2_i == '0);
    assign overflow  = signed_in && (Data1_i == INT_MIN) && (Data2_i == '1);

    // Partial remainder stays below the divisor, so the 33rd bit only exists
    // transiently in the shifted value and the trial difference.
    assign rem_sh = {rem_q, dvd_q[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign q_fix  = (sign1_q ^ sign2_q) ? -dvd_q : dvd_q;
    assign r_fix  = sign1_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        result_d = result_q;

        if (Flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            op_d    = DivOp_i;
            sign1_d = neg1_in;
            sign2_d = neg2_in;
            dvd_d   = neg1_in ? -Data1_i : Data1_i;
            dvs_d   = neg2_in ? -Data2_i : Data2_i;
            rem_d   = '0;
            cnt_d   = '0;
            if (div_zero) begin
                result_d = DivOp_i[1] ? Data1_i : '1;
                state_d  = S_DONE;
            end else if (overflow) begin
                result_d = DivOp_i[1] ? '0 : INT_MIN;
                state_d  = S_DONE;
            end else begin
                state_d = S_CALC;
            end
        end else begin
            case (state_q)
                S_CALC: begin
                    // Quotient bits shift into the dividend register as it empties.
                    if (!diff[DATA_W]) begin
                        rem_d = diff[DATA_W-1:0];
                    end else begin
                        rem_d = rem_sh[DATA_W-1:0];
                    end
                    dvd_d = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};
                    if (cnt_q == LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_FIX: begin
                    result_d = op_q[1] ? r_fix : q_fix;
                    state_d  = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign Busy_o      = (state_q == S_CALC) || (state_q == S_FIX);
    assign Done_o      = (state_q == S_DONE);
    assign DivResult_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results, latency and busy-time
// checks, abort paths and back-to-back requests.
module tb_div_unit;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Start_i;
    logic        Flush_i;
    logic [1:0]  DivOp_i;
    logic [31:0] Data1_i;
    logic [31:0] Data2_i;
    logic        Busy_o;
    logic        Done_o;
    logic [31:0] DivResult_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_res;

    div_unit #(.DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .Start_i     (Start_i),
        .Flush_i     (Flush_i),
        .DivOp_i     (DivOp_i),
        .Data1_i     (Data1_i),
        .Data2_i     (Data2_i),
        .Busy_o      (Busy_o),
        .Done_o      (Done_o),
        .DivResult_o (DivResult_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request, scramble operands after accept, measure latency and
    // busy cycles. With poke set, a conflicting Start_i is pulsed during CALC.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit poke);
        int lat;
        int busy_cnt;
        Start_i = 1'b1;
        DivOp_i = op;
        Data1_i = a;
        Data2_i = b;
        tick();
        Start_i = 1'b0;
        Data1_i = $urandom;
        Data2_i = $urandom;
        lat      = 1;
        busy_cnt = 0;
        while (!Done_o && lat < 200) begin
            if (Busy_o) busy_cnt++;
            if (poke && lat == 5) begin
                Start_i = 1'b1;
                DivOp_i = OP_DIVU;
                Data1_i = 32'd7;
                Data2_i = 32'd0;
            end else begin
                Start_i = 1'b0;
            end
            tick();
            lat++;
        end
        Start_i = 1'b0;
        check({tag, " result"}, DivResult_o, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), (exp_lat == 1) ? 32'd0 : 32'd33);
        last_res = exp;
        tick();
        check({tag, " done_pulse"}, {31'd0, Done_o}, 32'd0);
        check({tag, " result_hold"}, DivResult_o, exp);
    endtask

    task automatic abort_test(input string tag, input bit use_rst, input logic [31:0] exp_res);
        int dones;
        Start_i = 1'b1;
        DivOp_i = OP_DIVU;
        Data1_i = 32'd12345;
        Data2_i = 32'd7;
        tick();
        Start_i = 1'b0;
        repeat (9) tick();
        if (use_rst) rst_i = 1'b1;
        else         Flush_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        Flush_i = 1'b0;
        check({tag, " busy_after"}, {31'd0, Busy_o}, 32'd0);
        dones = 0;
        repeat (40) begin
            if (Done_o) dones++;
            tick();
        end
        check({tag, " no_done"}, 32'(dones), 32'd0);
        check({tag, " result"}, DivResult_o, exp_res);
    endtask

    initial begin
        int lat;
        int dones;
        rst_i   = 1'b1;
        Start_i = 1'b0;
        Flush_i = 1'b0;
        DivOp_i = 2'd0;
        Data1_i = '0;
        Data2_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        check("reset busy", {31'd0, Busy_o}, 32'd0);
        check("reset done", {31'd0, Done_o}, 32'd0);
        check("reset result", DivResult_o, 32'd0);

        run_op("div 100/-7",      OP_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, 1'b0);
        run_op("divu max/10",     OP_DIVU, 32'hFFFFFFFF, 32'd10,       32'h19999999, 34, 1'b0);
        run_op("div -100/-7",     OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       34, 1'b0);
        run_op("rem -100/7",      OP_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34, 1'b0);
        run_op("rem 100/-7",      OP_REM,  32'd100,      32'hFFFFFFF9, 32'd2,        34, 1'b0);
        run_op("remu max/10",     OP_REMU, 32'hFFFFFFFF, 32'd10,       32'd5,        34, 1'b0);
        run_op("div 5/0",         OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
        run_op("divu 5/0",        OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
        run_op("rem 5/0",         OP_REM,  32'd5,        32'd0,        32'd5,        1,  1'b0);
        run_op("remu min/0",      OP_REMU, 32'h80000000, 32'd0,        32'h80000000, 1,  1'b0);
        run_op("div ovf",         OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
        run_op("rem ovf",         OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);
        run_op("divu min/-1",     OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 1'b0);
        run_op("div poke",        OP_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, 1'b1);

        abort_test("flush", 1'b0, last_res);
        abort_test("reset", 1'b1, 32'd0);

        Start_i = 1'b1;
        Flush_i = 1'b1;
        DivOp_i = OP_DIV;
        Data1_i = 32'd5;
        Data2_i = 32'd0;
        tick();
        Start_i = 1'b0;
        Flush_i = 1'b0;
        dones = 0;
        repeat (5) begin
            if (Done_o || Busy_o) dones++;
            tick();
        end
        check("start+flush idle", 32'(dones), 32'd0);

        Start_i = 1'b1;
        DivOp_i = OP_DIVU;
        Data1_i = 32'd1000;
        Data2_i = 32'd3;
        tick();
        DivOp_i = OP_REMU;
        lat = 1;
        while (!Done_o && lat < 200) begin tick(); lat++; end
        check("b2b first result", DivResult_o, 32'd333);
        check("b2b first latency", 32'(lat), 32'd34);
        tick();
        Start_i = 1'b0;
        check("b2b no bubble busy", {31'd0, Busy_o}, 32'd1);
        lat = 1;
        while (!Done_o && lat < 200) begin tick(); lat++; end
        check("b2b second result", DivResult_o, 32'd1);
        check("b2b second latency", 32'(lat), 32'd34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
